// File: rtl/process_scheduler_pkg.sv
// Shared definitions for the round-robin process scheduler: FSM state
// encoding, the OS process id and the default quantum length.
package zeus_sched_pkg;

  typedef enum logic [1:0] {
    S_OS       = 2'd0,
    S_DISPATCH = 2'd1,
    S_RUN      = 2'd2,
    S_PREEMPT  = 2'd3
  } sched_state_t;

  localparam int PROC_OS     = 0;
  localparam int QUANTUM_DEF = 30;

endpackage

// File: rtl/process_scheduler_if.sv
// Scheduler <-> control unit / preemption manager signal bundle.
interface process_scheduler_if #(
  parameter int NUM_PROC = 2,
  parameter int CNT_W    = 5
);
  localparam int PROC_W = $clog2(NUM_PROC + 1);

  logic                os_dispatch_req;
  logic                instr_retired;
  logic                halt_seen;
  logic [PROC_W-1:0]   jump_prog;
  logic                flag_preempt;
  logic [PROC_W-1:0]   cur_proc;
  logic [CNT_W-1:0]    quantum_left;
  logic [NUM_PROC-1:0] proc_done;
  logic                all_done;

  modport master (
    output os_dispatch_req, instr_retired, halt_seen,
    input  jump_prog, flag_preempt, cur_proc, quantum_left, proc_done, all_done
  );

  modport slave (
    input  os_dispatch_req, instr_retired, halt_seen,
    output jump_prog, flag_preempt, cur_proc, quantum_left, proc_done, all_done
  );
endinterface

// File: rtl/quantum_counter.sv
// Per-dispatch instruction budget: loads the quantum, counts retirements
// down without underflow, and flags the retirement that empties it.
module quantum_counter #(
  parameter int CNT_W   = 5,
  parameter int QUANTUM = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  // The final retirement is seen while count is still 1, so the FSM can
  // register the preempt on the same edge that count reaches 0.
  assign expire = dec && (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(QUANTUM);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin user-process scheduler: picks the next unfinished process,
// meters its quantum and raises a one-cycle return-to-OS pulse.
module process_scheduler
  import zeus_sched_pkg::*;
#(
  parameter int NUM_PROC = 2,
  parameter int QUANTUM  = QUANTUM_DEF,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  process_scheduler_if.slave bus
);

  localparam int PROC_W = $clog2(NUM_PROC + 1);

  sched_state_t        state_q, state_d;
  logic [PROC_W-1:0]   jump_q, jump_d;
  logic                flag_q, flag_d;
  logic [PROC_W-1:0]   cur_q, cur_d;
  logic [PROC_W-1:0]   last_q, last_d;
  logic [NUM_PROC-1:0] done_q, done_d;
  logic                all_done_q;

  logic [PROC_W-1:0]   pick;
  logic                pick_found;
  logic                q_load, q_dec, q_expire;
  logic [CNT_W-1:0]    q_count;

  quantum_counter #(
    .CNT_W   (CNT_W),
    .QUANTUM (QUANTUM)
  ) u_quantum (
    .clk    (clk),
    .reset  (reset),
    .load   (q_load),
    .dec    (q_dec),
    .count  (q_count),
    .expire (q_expire)
  );

  // First id after last_q (wrapping) whose done bit is still clear.
  always_comb begin
    pick       = PROC_W'(PROC_OS);
    pick_found = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      automatic int cand = (int'(last_q) + i) % NUM_PROC;
      if (!pick_found && ((done_q & (NUM_PROC'(1) << cand)) == '0)) begin
        pick_found = 1'b1;
        pick       = PROC_W'(cand + 1);
      end
    end
  end

  // NOTE: every signal written here gets its default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    jump_d  = '0;
    flag_d  = 1'b0;
    cur_d   = cur_q;
    last_d  = last_q;
    done_d  = done_q;
    q_load  = 1'b0;
    q_dec   = 1'b0;

    case (state_q)
      S_OS: begin
        cur_d = PROC_W'(PROC_OS);
        if (bus.os_dispatch_req && !all_done_q && pick_found) begin
          state_d = S_DISPATCH;
          jump_d  = pick;
          cur_d   = pick;
          q_load  = 1'b1;
        end
      end
      S_DISPATCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        q_dec = bus.instr_retired;
        // HALT wins over a coinciding expiry; both lead to one preempt.
        if (bus.halt_seen) begin
          done_d  = done_q | (NUM_PROC'(1) << (cur_q - PROC_W'(1)));
          state_d = S_PREEMPT;
          flag_d  = 1'b1;
        end else if (q_expire) begin
          state_d = S_PREEMPT;
          flag_d  = 1'b1;
        end
      end
      S_PREEMPT: begin
        last_d  = cur_q;
        state_d = S_OS;
        cur_d   = PROC_W'(PROC_OS);
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_OS;
      jump_q     <= '0;
      flag_q     <= 1'b0;
      cur_q      <= '0;
      last_q     <= PROC_W'(NUM_PROC);
      done_q     <= '0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      jump_q     <= jump_d;
      flag_q     <= flag_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      done_q     <= done_d;
      all_done_q <= &done_q;
    end
  end

  assign bus.jump_prog    = jump_q;
  assign bus.flag_preempt = flag_q;
  assign bus.cur_proc     = cur_q;
  assign bus.quantum_left = q_count;
  assign bus.proc_done    = done_q;
  assign bus.all_done     = all_done_q;

endmodule
